// File: rtl/exp5_unidade_controle_desafio.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | exp5_unidade_controle_desafio                                          |
// | Moore control unit that sequences the memory-game datapath by rounds.  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module exp5_unidade_controle_desafio #(
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       nivel_in,
  input  logic       fimE,
  input  logic       enderecoIgualLimite,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       controle_timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       contaT,
  output logic       nivel,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    ST_INICIAL        = 4'h0,
    ST_PREPARACAO     = 4'h1,
    ST_INICIA_RODADA  = 4'h2,
    ST_ESPERA_JOGADA  = 4'h3,
    ST_REGISTRA       = 4'h4,
    ST_COMPARACAO     = 4'h5,
    ST_PROXIMA_JOGADA = 4'h6,
    ST_PROXIMA_RODADA = 4'h7,
    ST_FIM_ACERTO     = 4'hA,
    ST_FIM_TIMEOUT    = 4'hD,
    ST_FIM_ERRO       = 4'hE
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_final;
  logic   w_latch_nivel;

  function automatic state_t f_next(input state_t s);
    case (s)
      ST_INICIAL:        f_next = iniciar ? ST_PREPARACAO : ST_INICIAL;
      ST_PREPARACAO:     f_next = ST_INICIA_RODADA;
      ST_INICIA_RODADA:  f_next = ST_ESPERA_JOGADA;
      // A play arriving together with the timeout still counts.
      ST_ESPERA_JOGADA: begin
        if (jogada_feita)                        f_next = ST_REGISTRA;
        else if (controle_timeout && TIMEOUT_EN) f_next = ST_FIM_TIMEOUT;
        else                                     f_next = ST_ESPERA_JOGADA;
      end
      ST_REGISTRA:       f_next = ST_COMPARACAO;
      ST_COMPARACAO: begin
        if (!igual)                    f_next = ST_FIM_ERRO;
        else if (!enderecoIgualLimite) f_next = ST_PROXIMA_JOGADA;
        else if (fimE)                 f_next = ST_FIM_ACERTO;
        else                           f_next = ST_PROXIMA_RODADA;
      end
      ST_PROXIMA_JOGADA: f_next = ST_ESPERA_JOGADA;
      ST_PROXIMA_RODADA: f_next = ST_INICIA_RODADA;
      ST_FIM_ACERTO,
      ST_FIM_ERRO,
      ST_FIM_TIMEOUT:    f_next = iniciar ? ST_PREPARACAO : s;
      default:           f_next = ST_INICIAL;
    endcase
  endfunction

  // {zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT, pronto, acertou, errou, timeout}
  function automatic logic [10:0] f_outs(input state_t s);
    case (s)
      ST_PREPARACAO:     f_outs = 11'b101_0100_0000;
      ST_INICIA_RODADA:  f_outs = 11'b100_0100_0000;
      ST_ESPERA_JOGADA:  f_outs = {6'b000000, TIMEOUT_EN, 4'b0000};
      ST_REGISTRA:       f_outs = 11'b000_0010_0000;
      ST_PROXIMA_JOGADA: f_outs = 11'b010_0000_0000;
      ST_PROXIMA_RODADA: f_outs = 11'b000_1000_0000;
      ST_FIM_ACERTO:     f_outs = 11'b000_0000_1100;
      ST_FIM_ERRO:       f_outs = 11'b000_0000_1010;
      ST_FIM_TIMEOUT:    f_outs = 11'b000_0000_1001;
      default:           f_outs = 11'b000_0000_0000;
    endcase
  endfunction

  assign w_next        = f_next(r_state);
  assign w_final       = (r_state == ST_FIM_ACERTO) || (r_state == ST_FIM_ERRO) ||
                         (r_state == ST_FIM_TIMEOUT);
  assign w_latch_nivel = iniciar && ((r_state == ST_INICIAL) || w_final);
  assign db_estado     = r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_INICIAL;
      nivel   <= 1'b0;
      {zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT,
       pronto, acertou, errou, timeout} <= 11'b0;
    end else begin
      r_state <= w_next;
      if (w_latch_nivel) nivel <= nivel_in;
      // Outputs are decoded from the next state so they line up with r_state.
      {zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT,
       pronto, acertou, errou, timeout} <= f_outs(w_next);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exp5_unidade_controle_desafio.sv
`default_nettype none
// Self-checking bench for exp5_unidade_controle_desafio: directed game scenarios
// followed by random stimulus, checked against a reference model through a scoreboard.
module tb_exp5_unidade_controle_desafio;

  logic       clock = 1'b0;
  logic       reset, iniciar, nivel_in, fimE, enderecoIgualLimite;
  logic       jogada_feita, igual, controle_timeout;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT;
  logic       nivel, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  exp5_unidade_controle_desafio #(.TIMEOUT_EN(1'b1)) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .nivel_in            (nivel_in),
    .fimE                (fimE),
    .enderecoIgualLimite (enderecoIgualLimite),
    .jogada_feita        (jogada_feita),
    .igual               (igual),
    .controle_timeout    (controle_timeout),
    .zeraE               (zeraE),
    .contaE              (contaE),
    .zeraL               (zeraL),
    .contaL              (contaL),
    .zeraR               (zeraR),
    .registraR           (registraR),
    .contaT              (contaT),
    .nivel               (nivel),
    .pronto              (pronto),
    .acertou             (acertou),
    .errou               (errou),
    .timeout             (timeout),
    .db_estado           (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  st;
    logic        nv;
    logic [10:0] outs;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] m_state = 4'h0;
  logic       m_nivel = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT, pronto, acertou, errou, timeout}
  function automatic logic [10:0] m_outs(input logic [3:0] s);
    case (s)
      4'h1:    m_outs = 11'b10101000000;
      4'h2:    m_outs = 11'b10001000000;
      4'h3:    m_outs = 11'b00000010000;
      4'h4:    m_outs = 11'b00000100000;
      4'h6:    m_outs = 11'b01000000000;
      4'h7:    m_outs = 11'b00010000000;
      4'hA:    m_outs = 11'b00000001100;
      4'hE:    m_outs = 11'b00000001010;
      4'hD:    m_outs = 11'b00000001001;
      default: m_outs = 11'b00000000000;
    endcase
  endfunction

  task automatic step(input string lbl, input logic rst, input logic ini, input logic nin,
                      input logic jf, input logic ct, input logic ig, input logic el,
                      input logic fe);
    exp_t e;
    logic [3:0] ns;
    @(negedge clock);
    reset = rst; iniciar = ini; nivel_in = nin; jogada_feita = jf;
    controle_timeout = ct; igual = ig; enderecoIgualLimite = el; fimE = fe;
    ns = m_state;
    if (rst) begin
      ns = 4'h0; m_nivel = 1'b0;
    end else begin
      case (m_state)
        4'h0: if (ini) begin ns = 4'h1; m_nivel = nin; end
        4'h1: ns = 4'h2;
        4'h2: ns = 4'h3;
        4'h3: ns = jf ? 4'h4 : (ct ? 4'hD : 4'h3);
        4'h4: ns = 4'h5;
        4'h5: ns = !ig ? 4'hE : (!el ? 4'h6 : (fe ? 4'hA : 4'h7));
        4'h6: ns = 4'h3;
        4'h7: ns = 4'h2;
        4'hA, 4'hD, 4'hE: if (ini) begin ns = 4'h1; m_nivel = nin; end
        default: ns = 4'h0;
      endcase
    end
    m_state = ns;
    sb_q.push_back('{st: ns, nv: m_nivel, outs: m_outs(ns)});
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check_eq({lbl, " estado"}, {28'd0, db_estado}, {28'd0, e.st});
    check_eq({lbl, " nivel"}, {31'd0, nivel}, {31'd0, e.nv});
    check_eq({lbl, " saidas"},
             {21'd0, zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT,
              pronto, acertou, errou, timeout}, {21'd0, e.outs});
  endtask

  initial begin
    //     label        rst ini nin jf ct ig el fe
    step("reset",       1, 0, 0, 0, 0, 0, 0, 0);
    step("idle",        0, 0, 1, 1, 1, 0, 0, 0);
    step("start",       0, 1, 1, 0, 0, 0, 0, 0);
    step("prep",        0, 0, 0, 0, 0, 0, 0, 0);
    step("inicia",      0, 0, 0, 0, 0, 0, 0, 0);
    // round 0 completes and advances the limit; iniciar and nivel_in ignored mid-game
    step("r0 jogada",   0, 0, 0, 1, 0, 1, 1, 0);
    step("r0 compara",  0, 1, 0, 0, 0, 1, 1, 0);
    step("r0 proxrod",  0, 0, 0, 0, 0, 1, 1, 0);
    step("r0 inicia",   0, 0, 0, 1, 0, 1, 1, 0);
    step("r0 espera",   0, 0, 0, 0, 0, 1, 1, 0);
    // mid-round correct play
    step("mid jogada",  0, 0, 0, 1, 0, 1, 0, 0);
    step("mid compara", 0, 0, 0, 0, 0, 1, 0, 0);
    step("mid proxjog", 0, 0, 0, 0, 0, 1, 0, 0);
    step("mid espera",  0, 0, 0, 0, 0, 1, 0, 0);
    // play and timeout together: play wins, then mismatch
    step("sim jogada",  0, 0, 0, 1, 1, 0, 0, 0);
    step("sim compara", 0, 0, 0, 0, 0, 0, 0, 0);
    step("erro",        0, 0, 0, 0, 0, 0, 0, 0);
    step("erro hold",   0, 0, 0, 1, 1, 0, 0, 0);
    step("restart",     0, 1, 0, 0, 0, 0, 0, 0);
    step("rs inicia",   0, 0, 0, 0, 0, 0, 0, 0);
    step("rs espera",   0, 0, 0, 0, 0, 0, 0, 0);
    step("wait",        0, 0, 0, 0, 0, 0, 0, 0);
    // timeout alone
    step("timeout",     0, 0, 0, 0, 1, 0, 0, 0);
    step("to hold",     0, 0, 1, 1, 1, 0, 0, 0);
    step("to restart",  0, 1, 1, 0, 0, 0, 0, 0);
    step("w inicia",    0, 0, 0, 0, 0, 0, 0, 0);
    step("w espera",    0, 0, 0, 0, 0, 0, 0, 0);
    // last play of the full sequence
    step("w jogada",    0, 0, 0, 1, 0, 1, 1, 1);
    step("w compara",   0, 0, 0, 0, 0, 1, 1, 1);
    step("acerto",      0, 0, 0, 0, 0, 1, 1, 1);
    step("ac hold",     0, 0, 0, 0, 0, 0, 0, 0);
    step("ac restart",  0, 1, 0, 0, 0, 0, 0, 0);
    step("x inicia",    0, 0, 0, 0, 0, 0, 0, 0);
    step("x espera",    0, 0, 0, 0, 0, 0, 0, 0);
    step("mid reset",   1, 0, 0, 0, 0, 0, 0, 0);
    step("post reset",  0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(49) == 0), ($urandom_range(3) == 0), 1'($urandom_range(1)),
           ($urandom_range(2) == 0), ($urandom_range(3) == 0), ($urandom_range(4) != 0),
           1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
